// File: rtl/tlul_pkg.sv
// Minimal TL-UL D-channel types, response integrity extraction and the
// inverted SECDED encoders (64/57 for the response header, 39/32 for data).
package tlul_pkg;

    localparam int DataMaxWidth   = 32;
    localparam int D2HRspMaxWidth = 57;
    localparam int RspIntgWidth   = 7;
    localparam int DataIntgWidth  = 7;

    typedef struct packed {
        logic [RspIntgWidth-1:0]  rsp_intg;
        logic [DataIntgWidth-1:0] data_intg;
    } tl_d2h_user_t;

    typedef struct packed {
        logic                    d_valid;
        logic [2:0]              d_opcode;
        logic [2:0]              d_param;
        logic [1:0]              d_size;
        logic [7:0]              d_source;
        logic                    d_sink;
        logic [DataMaxWidth-1:0] d_data;
        tl_d2h_user_t            d_user;
        logic                    d_error;
        logic                    a_ready;
    } tl_d2h_t;

    typedef struct packed {
        logic [2:0] opcode;
        logic [1:0] size;
        logic       error;
    } tl_d2h_rsp_intg_t;

    function automatic tl_d2h_rsp_intg_t extract_d2h_rsp_intg(input tl_d2h_t tl);
        tl_d2h_rsp_intg_t r;
        r.opcode = tl.d_opcode;
        r.size   = tl.d_size;
        r.error  = tl.d_error;
        return r;
    endfunction

    function automatic logic [63:0] secded_inv_64_57_enc(input logic [56:0] d);
        logic [63:0] c;
        c     = {7'd0, d};
        c[57] = ^(c & 64'h0103FFF800007FFF);
        c[58] = ^(c & 64'h017C1FF801FF801F);
        c[59] = ^(c & 64'h01BDE1F87E0781E1);
        c[60] = ^(c & 64'h01DEEE3B8E388E22);
        c[61] = ^(c & 64'h01EF76CDB2C93244);
        c[62] = ^(c & 64'h01F7BB56D5525488);
        c[63] = ^(c & 64'h01FBDDA769A46910);
        return c ^ 64'h5400000000000000;
    endfunction

    function automatic logic [38:0] secded_inv_39_32_enc(input logic [31:0] d);
        logic [38:0] c;
        c     = {7'd0, d};
        c[32] = ^(c & 39'h002606BD25);
        c[33] = ^(c & 39'h00DEBA8050);
        c[34] = ^(c & 39'h00413D89AA);
        c[35] = ^(c & 39'h0031234ED1);
        c[36] = ^(c & 39'h00C2C1323B);
        c[37] = ^(c & 39'h002DCC624C);
        c[38] = ^(c & 39'h0098505586);
        return c ^ 39'h2A00000000;
    endfunction

endpackage

// File: rtl/tlul_rsp_intg_arb_pkg.sv
// Constants shared by the TL-UL response arbiter and its round-robin core.
package tlul_rsp_intg_arb_pkg;

    localparam int TlRspArbMaxSrc = 8;
    localparam int TlRspArbMinSrc = 2;

    function automatic bit num_src_legal(input int n);
        return (n >= TlRspArbMinSrc) && (n <= TlRspArbMaxSrc);
    endfunction

endpackage

// File: rtl/tlul_rsp_rr_arb.sv
// Round-robin winner search: the pointer source has highest priority and
// moves to one past the winner whenever a grant is taken.
module tlul_rsp_rr_arb #(
    parameter  int N    = 4,
    localparam int IdxW = $clog2(N)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N-1:0]    req_i,
    input  logic            advance_i,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);

    logic [IdxW-1:0] r_ptr;
    logic [IdxW-1:0] w_cand;

    // Walk offsets from farthest to nearest so the closest requester wins.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        w_cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_cand = IdxW'((int'(r_ptr) + k) % N);
            if (req_i[w_cand]) begin
                valid_o = 1'b1;
                idx_o   = w_cand;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr <= '0;
        end else if (advance_i && valid_o) begin
            r_ptr <= (idx_o == IdxW'(N - 1)) ? '0 : idx_o + 1'b1;
        end
    end

endmodule

// File: rtl/tlul_rsp_intg_arb.sv
// Merges NumSrc TL-UL response channels into one registered response.
// Define TLUL_RSP_ARB_INTG_GEN_EN to regenerate rsp_intg/data_intg for the winner.
module tlul_rsp_intg_arb
    import tlul_pkg::*;
    import tlul_rsp_intg_arb_pkg::*;
#(
    parameter  int NumSrc      = 4,
    parameter  bit LockOnStall = 1'b1,
    localparam int IdxW        = $clog2(NumSrc)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  tl_d2h_t [NumSrc-1:0]         tl_src_i,
    output logic    [NumSrc-1:0]         src_ready_o,
    output tl_d2h_t                      tl_o,
    input  logic                         d_ready_i,
    output logic    [IdxW-1:0]           gnt_idx_o
);

    if (!num_src_legal(NumSrc)) begin : g_num_src_check
        $fatal(1, "tlul_rsp_intg_arb: NumSrc must be within 2..8");
    end

    tl_d2h_t           r_out;
    logic [IdxW-1:0]   r_gnt;
    logic              w_accept;
    logic              w_win_valid;
    logic [IdxW-1:0]   w_win_idx;
    logic [NumSrc-1:0] w_req;
    tl_d2h_t           w_win_rsp;

    // The register only ever refills when empty or draining, so both
    // stall policies reduce to the same accept term.
    assign w_accept = LockOnStall ? (~r_out.d_valid | d_ready_i)
                                  : (~r_out.d_valid | d_ready_i);

    for (genvar gi = 0; gi < NumSrc; gi++) begin : g_src
        assign w_req[gi]       = tl_src_i[gi].d_valid;
        assign src_ready_o[gi] = w_accept & ~rst_i & w_win_valid
                               & (w_win_idx == IdxW'(gi));
    end

    tlul_rsp_rr_arb #(
        .N (NumSrc)
    ) u_rr_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (w_req),
        .advance_i (w_accept),
        .idx_o     (w_win_idx),
        .valid_o   (w_win_valid)
    );

`ifdef TLUL_RSP_ARB_INTG_GEN_EN
    logic [63:0] w_rsp_cw;
    logic [38:0] w_data_cw;

    always_comb begin
        w_win_rsp = tl_src_i[w_win_idx];
        w_rsp_cw  = secded_inv_64_57_enc(
            {{(D2HRspMaxWidth - $bits(tl_d2h_rsp_intg_t)){1'b0}},
             extract_d2h_rsp_intg(w_win_rsp)});
        w_data_cw = secded_inv_39_32_enc(w_win_rsp.d_data);
        w_win_rsp.d_user.rsp_intg  = w_rsp_cw[63:57];
        w_win_rsp.d_user.data_intg = w_data_cw[38:32];
    end
`else
    always_comb begin
        w_win_rsp = tl_src_i[w_win_idx];
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out <= '0;
            r_gnt <= '0;
        end else if (w_accept) begin
            if (w_win_valid) begin
                r_out <= w_win_rsp;
                r_gnt <= w_win_idx;
            end else begin
                r_out.d_valid <= 1'b0;
            end
        end
    end

    assign tl_o      = r_out;
    assign gnt_idx_o = r_gnt;

endmodule

// File: tb/tb_tlul_rsp_intg_arb.sv
// Bench for tlul_rsp_intg_arb: directed scenarios then random traffic, all
// checked against a transaction-level model of the arbiter.
module tb_tlul_rsp_intg_arb;
    import tlul_pkg::*;

    localparam int N = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    tl_d2h_t [N-1:0]      src;
    logic    [N-1:0]      src_ready;
    tl_d2h_t              tl_out;
    logic                 d_ready;
    logic    [1:0]        gnt;

    always #5 clk = ~clk;

    tlul_rsp_intg_arb #(
        .NumSrc      (N),
        .LockOnStall (1'b1)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .tl_src_i    (src),
        .src_ready_o (src_ready),
        .tl_o        (tl_out),
        .d_ready_i   (d_ready),
        .gnt_idx_o   (gnt)
    );

    int      vectors     = 0;
    int      miscompares = 0;
    bit      m_valid     = 1'b0;
    tl_d2h_t m_out       = '0;
    int      m_gnt       = 0;
    int      m_ptr       = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic tl_d2h_t new_rsp(input int i);
        tl_d2h_t r;
        r          = '0;
        r.d_valid  = 1'b1;
        r.d_opcode = 3'($urandom);
        r.d_param  = 3'($urandom);
        r.d_size   = 2'($urandom);
        r.d_source = 8'(i);
        r.d_sink   = 1'($urandom);
        r.d_data   = $urandom;
        r.d_user   = 14'($urandom);
        r.d_error  = 1'($urandom);
        r.a_ready  = 1'($urandom);
        return r;
    endfunction

    // Expected content of the output register for a granted source response.
    function automatic tl_d2h_t expect_rsp(input tl_d2h_t s);
        tl_d2h_t r;
        r = s;
`ifdef TLUL_RSP_ARB_INTG_GEN_EN
        begin
            logic [63:0] rc;
            logic [38:0] dc;
            rc = secded_inv_64_57_enc({51'd0, s.d_opcode, s.d_size, s.d_error});
            dc = secded_inv_39_32_enc(s.d_data);
            r.d_user.rsp_intg  = rc[63:57];
            r.d_user.data_intg = dc[38:32];
        end
`endif
        return r;
    endfunction

    // First valid source found walking from the priority pointer, or -1.
    function automatic int pick();
        int order[$];
        for (int k = 0; k < N; k++) order.push_back((m_ptr + k) % N);
        foreach (order[j]) begin
            if (src[order[j]].d_valid) return order[j];
        end
        return -1;
    endfunction

    // One clock: check src_ready, advance the model, then check registered outputs.
    task automatic tick(input bit do_rst, input logic [N-1:0] refill, input int new_pct);
        int          w;
        bit          acc;
        logic [N-1:0] one;
        logic [N-1:0] exp_rdy;
        tl_d2h_t     cap;
        rst = do_rst;
        #1;
        acc = !m_valid || d_ready;
        w   = pick();
        one = '0;
        one[0] = 1'b1;
        exp_rdy = (!do_rst && acc && w >= 0) ? (one << w) : '0;
        chk("src_ready", 128'(src_ready), 128'(exp_rdy));
        cap = (w >= 0) ? src[w] : '0;
        @(posedge clk);
        if (do_rst) begin
            m_valid = 1'b0;
            m_gnt   = 0;
            m_ptr   = 0;
        end else if (acc) begin
            if (w >= 0) begin
                m_valid = 1'b1;
                m_out   = expect_rsp(cap);
                m_gnt   = w;
                m_ptr   = (w + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        if (!do_rst && acc && w >= 0) src[w] = refill[w] ? new_rsp(w) : '0;
        for (int i = 0; i < N; i++) begin
            if (!src[i].d_valid && int'($urandom_range(0, 99)) < new_pct) src[i] = new_rsp(i);
        end
        chk("d_valid", 128'(tl_out.d_valid), 128'(m_valid));
        if (m_valid) chk("tl_o", 128'(tl_out), 128'(m_out));
        chk("gnt_idx", 128'(gnt), 128'(m_gnt));
    endtask

    initial begin
        tl_d2h_t hold;
        logic [6:0] exp_intg;
        rst     = 1'b1;
        d_ready = 1'b0;
        for (int i = 0; i < N; i++) src[i] = new_rsp(i);

        // Reset with every source valid
        for (int k = 0; k < 3; k++) tick(1'b1, '1, 0);

        // Round robin with all sources valid and the host draining
        d_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, '1, 0);
            chk("rr_order", 128'(gnt), 128'(k % 4));
        end
        tick(1'b0, '1, 0);
        tick(1'b0, '1, 0);
        chk("pre_stall_gnt", 128'(gnt), 128'(2));

        // Stall with source 2 held in the output register
        d_ready = 1'b0;
        hold    = tl_out;
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, '1, 0);
            chk("stall_hold", 128'(tl_out), 128'(hold));
        end
        d_ready = 1'b1;
        tick(1'b0, '1, 0);
        chk("post_stall_gnt", 128'(gnt), 128'(3));

        // Sparse request: bring pointer to 2, then only source 1 valid
        tick(1'b0, '1, 0);
        tick(1'b0, '1, 0);
        chk("sparse_setup", 128'(gnt), 128'(1));
        for (int i = 0; i < N; i++) src[i] = '0;
        src[1] = new_rsp(1);
        tick(1'b0, '0, 0);
        chk("sparse_gnt", 128'(gnt), 128'(1));
        src[0] = new_rsp(0);
        src[2] = new_rsp(2);
        src[3] = new_rsp(3);
        tick(1'b0, '0, 0);
        chk("sparse_ptr", 128'(gnt), 128'(2));

        // Integrity fields with a corrupted rsp_intg
        for (int i = 0; i < N; i++) src[i] = '0;
        tick(1'b0, '0, 0);
        src[0] = new_rsp(0);
        src[0].d_data = 32'hDEADBEEF;
        src[0].d_user.rsp_intg = 7'h00;
        hold = expect_rsp(src[0]);
        exp_intg = hold.d_user.rsp_intg;
        tick(1'b0, '0, 0);
        chk("rsp_intg", 128'(tl_out.d_user.rsp_intg), 128'(exp_intg));
        chk("intg_data", 128'(tl_out.d_data), 128'(32'hDEADBEEF));

        // Reset pulse while stalled with a valid response
        for (int i = 0; i < N; i++) src[i] = new_rsp(i);
        d_ready = 1'b0;
        tick(1'b0, '1, 0);
        tick(1'b0, '1, 0);
        tick(1'b1, '1, 0);
        chk("midrst_valid", 128'(tl_out.d_valid), 128'(0));
        chk("midrst_gnt", 128'(gnt), 128'(0));
        d_ready = 1'b1;
        tick(1'b0, '1, 0);
        chk("first_after_rst", 128'(gnt), 128'(0));

        // Random traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            d_ready = ($urandom_range(0, 3) != 0);
            tick(($urandom_range(0, 63) == 0), '0, 40);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
